// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle RV32I sequencer: PC/IR ownership, memory handshakes, write gating.
// Optional performance counters are built when RV32I_PERF_CNT_EN is defined.

package rv32i_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_from_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic {
    REG_WE_OFF = 1'b0,
    REG_WE     = 1'b1
  } reg_we_e;
endpackage

module rv32i_seq_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  wb_from_e    dec_wb_from,
  input  mem_op_e     dec_mem_op,
  input  reg_we_e     dec_r_we,
  input  reg_we_e     dec_csr_we,
  input  logic [31:0] next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        mem_data_we,
  output logic        rf_we,
  output logic        csr_we,
  input  logic        halt_req,
  output logic        halted,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_rf_we;
  logic        r_csr_we;
  logic        r_halted;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_imem_fire;
  logic        w_dmem_fire;

  assign w_is_load   = (dec_wb_from == WB_MEM);
  assign w_is_store  = (dec_mem_op == MEM_STORE);
  // Acks only count while the matching request is actually raised.
  assign w_imem_fire = r_imem_req & imem_ack;
  assign w_dmem_fire = r_dmem_req & dmem_ack;

  // Outputs are registered from the next state, so each one is a pure
  // function of the current state as seen from outside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSTR;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_csr_we   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_rf_we  <= 1'b0;
      r_csr_we <= 1'b0;
      case (r_state)
        S_RST: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (w_imem_fire) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_load || w_is_store) begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_is_store;
          end else begin
            r_state  <= S_WB;
            r_rf_we  <= (dec_r_we == REG_WE);
            r_csr_we <= (dec_csr_we == REG_WE);
          end
        end
        S_MEM: begin
          if (w_dmem_fire) begin
            r_state    <= S_WB;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= (dec_r_we == REG_WE);
            r_csr_we   <= (dec_csr_we == REG_WE);
          end
        end
        S_WB: begin
          r_pc <= next_pc;
          if (halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_HALT: begin
          if (!halt_req) begin
            r_state    <= S_FETCH;
            r_halted   <= 1'b0;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_RST;
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign ir          = r_ir;
  assign pc          = r_pc;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign rf_we       = r_rf_we;
  assign csr_we      = r_csr_we;
  assign halted      = r_halted;
  // Load data is only valid in the ack cycle, so the MDR strobe follows the ack.
  assign mem_data_we = w_dmem_fire & w_is_load;

`ifdef RV32I_PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (r_state == S_WB) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = 64'h0;
  assign instret_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Self-checking bench for rv32i_seq_ctrl: table vectors, randomized instruction
// stream against an instruction-level timing model, and hand-written corner cases.

module tb_rv32i_seq_ctrl;
  import rv32i_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

`ifdef RV32I_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  wb_from_e    dec_wb_from;
  mem_op_e     dec_mem_op;
  reg_we_e     dec_r_we;
  reg_we_e     dec_csr_we;
  logic [31:0] next_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        mem_data_we;
  logic        rf_we;
  logic        csr_we;
  logic        halt_req;
  logic        halted;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  rv32i_seq_ctrl #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .pc         (pc),
    .dec_wb_from(dec_wb_from),
    .dec_mem_op (dec_mem_op),
    .dec_r_we   (dec_r_we),
    .dec_csr_we (dec_csr_we),
    .next_pc    (next_pc),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .mem_data_we(mem_data_we),
    .rf_we      (rf_we),
    .csr_we     (csr_we),
    .halt_req   (halt_req),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state at instruction granularity.
  logic [31:0]     model_pc      = RESET_PC;
  logic [31:0]     model_ir      = NOP_INSTR;
  longint unsigned model_instret = 0;
  longint unsigned tb_cycles     = 0;

  always @(posedge clk) begin
    tb_cycles <= rst_n ? tb_cycles + 1 : 0;
  end

  typedef struct {
    int          kind;
    int          fw;
    int          mw;
    bit          rwe;
    bit          cwe;
    logic [31:0] word;
    logic [31:0] npc;
    int          exp_cyc;
    int          exp_rf;
    int          exp_mdw;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level latency: fetch with waits, decode, exec, optional memory, write-back.
  function automatic int model_cycles(input int kind, input int fw, input int mw);
    return 4 + fw + ((kind == K_ALU) ? 0 : 1 + mw);
  endfunction

  task automatic drive_decoder(input int kind, input bit rwe, input bit cwe);
    wb_from_e wb_pick;
    case ($urandom_range(0, 2))
      0:       wb_pick = WB_ALU;
      1:       wb_pick = WB_PC4;
      default: wb_pick = WB_CSR;
    endcase
    dec_wb_from = (kind == K_LOAD) ? WB_MEM : wb_pick;
    dec_mem_op  = (kind == K_LOAD) ? MEM_LOAD : ((kind == K_STORE) ? MEM_STORE : MEM_NONE);
    dec_r_we    = rwe ? REG_WE : REG_WE_OFF;
    dec_csr_we  = cwe ? REG_WE : REG_WE_OFF;
  endtask

  // Runs one instruction from its first FETCH cycle until the next FETCH (or HALT).
  task automatic run_instr(input int kind, input int fw, input int mw, input bit rwe,
                           input bit cwe, input bit hlt, input logic [31:0] word,
                           input logic [31:0] npc, input int exp_cyc, input int exp_rf,
                           input int exp_mdw, input string tag);
    int cyc, fcnt, mcnt, nrf, ncsr, nmdw, rf_at;
    bit fetched, done, addr_ok, we_ok, ir_ok, excl_ok;
    cyc = 0; fcnt = 0; mcnt = 0; nrf = 0; ncsr = 0; nmdw = 0; rf_at = -1;
    fetched = 0; done = 0; addr_ok = 1; we_ok = 1; ir_ok = 1; excl_ok = 1;
    halt_req = 1'b0;
    next_pc  = npc;
    while (!done) begin
      if (imem_req) begin
        fcnt++;
        if (imem_addr !== model_pc) addr_ok = 0;
        if (ir !== model_ir) ir_ok = 0;
        if (fcnt > fw) begin
          imem_ack   = 1'b1;
          imem_rdata = word;
          fetched    = 1;
          halt_req   = hlt;
          drive_decoder(kind, rwe, cwe);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
        end
      end else begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      if (dmem_req) begin
        mcnt++;
        if (dmem_we !== (kind == K_STORE)) we_ok = 0;
        dmem_ack = (mcnt > mw);
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      if (imem_req && dmem_req) excl_ok = 0;
      #1;
      if (mem_data_we) nmdw++;
      if (rf_we) begin
        nrf++;
        rf_at = cyc + 1;
      end
      if (csr_we) ncsr++;
      step();
      cyc++;
      if (fetched && (imem_req || halted)) done = 1;
      if (cyc > 100) begin
        n_checks++;
        $display("FAIL %s timeout: got %0d cycles without completion, required %0d", tag, cyc, exp_cyc);
        done = 1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check({tag, " cycles"},       64'(cyc),   64'(exp_cyc));
    check({tag, " rf_we count"},  64'(nrf),   64'(exp_rf));
    check({tag, " rf_we in WB"},  64'(rf_at), (exp_rf != 0) ? 64'(exp_cyc) : 64'(-1));
    check({tag, " csr_we count"}, 64'(ncsr),  64'(cwe));
    check({tag, " mdr strobes"},  64'(nmdw),  64'(exp_mdw));
    check({tag, " fetch addr"},   64'(addr_ok), 64'd1);
    check({tag, " ir hold"},      64'(ir_ok),   64'd1);
    check({tag, " dmem_we"},      64'(we_ok),   64'd1);
    check({tag, " req excl"},     64'(excl_ok), 64'd1);
    check({tag, " pc"},           64'(pc),    64'(npc));
    check({tag, " ir"},           64'(ir),    64'(word));
    model_pc = npc;
    model_ir = word;
    model_instret++;
    $display("%s kind=%0d fw=%0d mw=%0d cycles=%0d rf=%0d csr=%0d pc=%08h",
             tag, kind, fw, mw, cyc, nrf, ncsr, pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{K_ALU,   0, 0, 1'b1, 1'b0, 32'h0050_0093, 32'h0000_0104, 4, 1, 0};
    vecs[1] = '{K_ALU,   3, 0, 1'b1, 1'b0, 32'h0010_8113, 32'h0000_0108, 7, 1, 0};
    vecs[2] = '{K_LOAD,  0, 2, 1'b1, 1'b0, 32'h0000_2183, 32'h0000_010C, 7, 1, 1};
    vecs[3] = '{K_STORE, 0, 0, 1'b0, 1'b0, 32'h0030_2223, 32'h0000_0110, 5, 0, 0};
    vecs[4] = '{K_ALU,   1, 0, 1'b1, 1'b1, 32'h3000_2273, 32'h0000_0114, 5, 1, 0};
    vecs[5] = '{K_LOAD,  0, 0, 1'b1, 1'b0, 32'h0040_2283, 32'hFFFF_FFFC, 5, 1, 1};
    vecs[6] = '{K_ALU,   0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 4, 0, 0};
    vecs[7] = '{K_STORE, 2, 3, 1'b0, 1'b0, 32'h0050_2423, 32'h0000_0004, 10, 0, 0};

    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    dmem_ack    = 1'b0;
    halt_req    = 1'b0;
    next_pc     = 32'h0;
    dec_wb_from = WB_ALU;
    dec_mem_op  = MEM_NONE;
    dec_r_we    = REG_WE_OFF;
    dec_csr_we  = REG_WE_OFF;

    // Reset state.
    repeat (3) step();
    check("reset pc", 64'(pc), 64'(RESET_PC));
    check("reset ir", 64'(ir), 64'(NOP_INSTR));
    check("reset reqs", 64'({imem_req, dmem_req, dmem_we, rf_we, csr_we, halted}), 64'd0);
    check("reset cycle_cnt", cycle_cnt, 64'd0);
    check("reset instret_cnt", instret_cnt, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst cycle imem_req", 64'(imem_req), 64'd0);
    step();
    check("first fetch req", 64'(imem_req), 64'd1);
    check("first fetch addr", 64'(imem_addr), 64'(RESET_PC));

    // Ten zero-wait ALU instructions straight after reset.
    for (int i = 0; i < 10; i++) begin
      run_instr(K_ALU, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0050_0093, model_pc + 32'd4,
                model_cycles(K_ALU, 0, 0), 1, 0, $sformatf("alu%0d", i));
    end
    check("perf cycle_cnt 10 alu", cycle_cnt, PERF ? 64'd41 : 64'd0);
    check("perf instret_cnt 10 alu", instret_cnt, PERF ? 64'd10 : 64'd0);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].kind, vecs[i].fw, vecs[i].mw, vecs[i].rwe, vecs[i].cwe, 1'b0,
                vecs[i].word, vecs[i].npc, vecs[i].exp_cyc, vecs[i].exp_rf,
                vecs[i].exp_mdw, $sformatf("vec%0d", i));
    end

    // Halt requested from fetch onward; instruction retires, then the core parks.
    run_instr(K_ALU, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h0000_0100,
              4, 1, 0, "halt");
    check("halt halted", 64'(halted), 64'd1);
    check("halt imem_req", 64'(imem_req), 64'd0);
    begin
      bit park_ok;
      park_ok = 1;
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        step();
        if (!halted || imem_req || dmem_req || rf_we) park_ok = 0;
      end
      check("halt parked", 64'(park_ok), 64'd1);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    halt_req = 1'b0;
    step();
    check("unhalt halted", 64'(halted), 64'd0);
    check("unhalt imem_req", 64'(imem_req), 64'd1);
    check("unhalt addr", 64'(imem_addr), 64'h100);
    $display("halt release pc=%08h", imem_addr);

    // Randomized instruction stream against the latency model.
    for (int i = 0; i < 40; i++) begin
      int k, fw, mw;
      bit rwe, cwe;
      k   = $urandom_range(0, 2);
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      rwe = (k != K_STORE) ? 1'($urandom_range(0, 1)) : 1'b0;
      cwe = (k == K_ALU) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_instr(k, fw, mw, rwe, cwe, 1'b0, $urandom, $urandom & 32'hFFFF_FFFC,
                model_cycles(k, fw, mw), int'(rwe), (k == K_LOAD) ? 1 : 0,
                $sformatf("rnd%0d", i));
    end
    check("perf cycle_cnt rnd", cycle_cnt, PERF ? 64'(tb_cycles) : 64'd0);
    check("perf instret_cnt rnd", instret_cnt, PERF ? 64'(model_instret) : 64'd0);

    // Reset during a load's memory wait, followed by a late ack.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_2083;
    drive_decoder(K_LOAD, 1'b1, 1'b0);
    next_pc    = 32'h0000_0200;
    step();
    imem_ack = 1'b0;
    step();
    step();
    check("rst-mem dmem_req", 64'(dmem_req), 64'd1);
    check("rst-mem dmem_we", 64'(dmem_we), 64'd0);
    step();
    check("rst-mem wait dmem_req", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    step();
    check("rst-mem drop reqs", 64'({imem_req, dmem_req, rf_we, csr_we}), 64'd0);
    dmem_ack = 1'b1;
    #1;
    check("rst-mem late ack mdr", 64'(mem_data_we), 64'd0);
    step();
    check("rst-mem no rf_we", 64'(rf_we), 64'd0);
    check("rst-mem pc", 64'(pc), 64'(RESET_PC));
    check("rst-mem ir", 64'(ir), 64'(NOP_INSTR));
    rst_n    = 1'b1;
    dmem_ack = 1'b0;
    #1;
    check("rst-mem rst cycle req", 64'(imem_req), 64'd0);
    step();
    check("rst-mem restart req", 64'(imem_req), 64'd1);
    check("rst-mem restart addr", 64'(imem_addr), 64'(RESET_PC));
    check("rst-mem cycle_cnt", cycle_cnt, PERF ? 64'd1 : 64'd0);
    check("rst-mem instret_cnt", instret_cnt, 64'd0);
    $display("reset-in-mem restart pc=%08h", imem_addr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
